// File: rtl/arch_state_seq_pkg.sv
// Shared definitions for the architectural state sequencer.
// Holds the x86 GPR index map (valid when NREGS=8) and the sequencer FSM encoding.
package arch_state_seq_pkg;

  localparam int unsigned REG_EAX = 0;
  localparam int unsigned REG_ECX = 1;
  localparam int unsigned REG_EDX = 2;
  localparam int unsigned REG_EBX = 3;
  localparam int unsigned REG_ESP = 4;
  localparam int unsigned REG_EBP = 5;
  localparam int unsigned REG_ESI = 6;
  localparam int unsigned REG_EDI = 7;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/arch_state_bank.sv
// One copy of architectural state: GPRs, EIP, EFLAGS and the retire counter.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ld                     load all fields from ld_* this cycle
//   ld_gpr/eip/eflags/cnt  values to load
//   q_gpr/eip/eflags/cnt   registered contents
module arch_state_bank #(
  parameter int unsigned         WIDTH      = 32,
  parameter int unsigned         NREGS      = 8,
  parameter int unsigned         CNT_W      = 16,
  parameter logic [WIDTH-1:0]    EFLAGS_RST = 32'h0000_0002
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld,
  input  logic [NREGS*WIDTH-1:0] ld_gpr,
  input  logic [WIDTH-1:0]       ld_eip,
  input  logic [WIDTH-1:0]       ld_eflags,
  input  logic [CNT_W-1:0]       ld_cnt,
  output logic [NREGS*WIDTH-1:0] q_gpr,
  output logic [WIDTH-1:0]       q_eip,
  output logic [WIDTH-1:0]       q_eflags,
  output logic [CNT_W-1:0]       q_cnt
);

  logic [NREGS*WIDTH-1:0] gpr_q, gpr_d;
  logic [WIDTH-1:0]       eip_q, eip_d;
  logic [WIDTH-1:0]       eflags_q, eflags_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_comb begin
    gpr_d    = gpr_q;
    eip_d    = eip_q;
    eflags_d = eflags_q;
    cnt_d    = cnt_q;
    if (ld) begin
      gpr_d    = ld_gpr;
      eip_d    = ld_eip;
      eflags_d = ld_eflags;
      cnt_d    = ld_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q    <= '0;
      eip_q    <= '0;
      eflags_q <= EFLAGS_RST;
      cnt_q    <= '0;
    end else begin
      gpr_q    <= gpr_d;
      eip_q    <= eip_d;
      eflags_q <= eflags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_gpr    = gpr_q;
  assign q_eip    = eip_q;
  assign q_eflags = eflags_q;
  assign q_cnt    = cnt_q;

endmodule

// File: rtl/arch_state_seq.sv
// Architectural state sequencer: holds live x86 state, retires commits with
// per-GPR masks, and supports a single save/restore checkpoint.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   init_valid, i_gpr/eip/eflags     load initial state (highest priority)
//   commit_valid/commit_ready        commit handshake (ready is combinational)
//   w_gpr, gpr_wrmask                candidate GPR values and write mask
//   next_eip, next_eflags            EIP/EFLAGS written on every commit
//   ckpt_save, ckpt_restore          snapshot / roll back
//   o_gpr/eip/eflags, o_retired      registered live state
//   o_loaded, o_ckpt_valid, o_err    status flags (o_err sticky)
module arch_state_seq
  import arch_state_seq_pkg::*;
#(
  parameter int unsigned         WIDTH      = 32,
  parameter int unsigned         NREGS      = 8,
  parameter int unsigned         CNT_W      = 16,
  parameter logic [WIDTH-1:0]    EFLAGS_RST = 32'h0000_0002
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_valid,
  input  logic [NREGS*WIDTH-1:0] i_gpr,
  input  logic [WIDTH-1:0]       i_eip,
  input  logic [WIDTH-1:0]       i_eflags,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic [NREGS*WIDTH-1:0] w_gpr,
  input  logic [NREGS-1:0]       gpr_wrmask,
  input  logic [WIDTH-1:0]       next_eip,
  input  logic [WIDTH-1:0]       next_eflags,
  input  logic                   ckpt_save,
  input  logic                   ckpt_restore,
  output logic [NREGS*WIDTH-1:0] o_gpr,
  output logic [WIDTH-1:0]       o_eip,
  output logic [WIDTH-1:0]       o_eflags,
  output logic [CNT_W-1:0]       o_retired,
  output logic                   o_loaded,
  output logic                   o_ckpt_valid,
  output logic                   o_err
);

  state_e state_q, state_d;
  logic   ckpt_valid_q, ckpt_valid_d;
  logic   err_q, err_d;

  logic [NREGS*WIDTH-1:0] live_gpr, snap_gpr, ld_gpr, merged_gpr;
  logic [WIDTH-1:0]       live_eip, snap_eip, ld_eip;
  logic [WIDTH-1:0]       live_eflags, snap_eflags, ld_eflags;
  logic [CNT_W-1:0]       live_cnt, snap_cnt, ld_cnt, cnt_inc;
  logic                   is_active, fire, restore_ok, save_ok, live_ld, bad_req;

  always_comb begin
    is_active    = (state_q == ST_ACTIVE);
    commit_ready = is_active && !init_valid && !ckpt_restore;
    fire         = commit_valid && commit_ready;
    restore_ok   = is_active && ckpt_restore && ckpt_valid_q;
    // Restore wins over a simultaneous save; init overrides both.
    save_ok      = is_active && ckpt_save && !ckpt_restore && !init_valid;
    bad_req      = (ckpt_restore && !ckpt_valid_q) ||
                   (!is_active && (ckpt_save || ckpt_restore || commit_valid));

    merged_gpr = live_gpr;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (gpr_wrmask[k]) merged_gpr[k*WIDTH +: WIDTH] = w_gpr[k*WIDTH +: WIDTH];
    end
    cnt_inc = (live_cnt == '1) ? live_cnt : live_cnt + CNT_W'(1);

    live_ld   = init_valid || restore_ok || fire;
    ld_gpr    = merged_gpr;
    ld_eip    = next_eip;
    ld_eflags = next_eflags;
    ld_cnt    = cnt_inc;
    if (init_valid) begin
      ld_gpr    = i_gpr;
      ld_eip    = i_eip;
      ld_eflags = i_eflags;
      ld_cnt    = '0;
    end else if (restore_ok) begin
      ld_gpr    = snap_gpr;
      ld_eip    = snap_eip;
      ld_eflags = snap_eflags;
      ld_cnt    = snap_cnt;
    end

    state_d      = state_q;
    ckpt_valid_d = ckpt_valid_q;
    err_d        = err_q;
    if (init_valid) begin
      state_d      = ST_ACTIVE;
      ckpt_valid_d = 1'b0;
      err_d        = 1'b0;
    end else begin
      if (save_ok) ckpt_valid_d = 1'b1;
      if (bad_req) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      ckpt_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ckpt_valid_q <= ckpt_valid_d;
      err_q        <= err_d;
    end
  end

  arch_state_bank #(
    .WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W), .EFLAGS_RST(EFLAGS_RST)
  ) u_live (
    .clk(clk), .rst_n(rst_n), .ld(live_ld),
    .ld_gpr(ld_gpr), .ld_eip(ld_eip), .ld_eflags(ld_eflags), .ld_cnt(ld_cnt),
    .q_gpr(live_gpr), .q_eip(live_eip), .q_eflags(live_eflags), .q_cnt(live_cnt)
  );

  // Snapshot samples the pre-edge live state, so a save alongside a commit
  // captures the values before that commit.
  arch_state_bank #(
    .WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W), .EFLAGS_RST(EFLAGS_RST)
  ) u_snap (
    .clk(clk), .rst_n(rst_n), .ld(save_ok),
    .ld_gpr(live_gpr), .ld_eip(live_eip), .ld_eflags(live_eflags), .ld_cnt(live_cnt),
    .q_gpr(snap_gpr), .q_eip(snap_eip), .q_eflags(snap_eflags), .q_cnt(snap_cnt)
  );

  assign o_gpr        = live_gpr;
  assign o_eip        = live_eip;
  assign o_eflags     = live_eflags;
  assign o_retired    = live_cnt;
  assign o_loaded     = is_active;
  assign o_ckpt_valid = ckpt_valid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_arch_state_seq.sv
module tb_arch_state_seq;
  import arch_state_seq_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned NW = N * W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          init_valid = 1'b0;
  logic [NW-1:0] i_gpr = '0;
  logic [W-1:0]  i_eip = '0, i_eflags = '0;
  logic          commit_valid = 1'b0;
  logic [NW-1:0] w_gpr = '0;
  logic [N-1:0]  gpr_wrmask = '0;
  logic [W-1:0]  next_eip = '0, next_eflags = '0;
  logic          ckpt_save = 1'b0, ckpt_restore = 1'b0;

  logic          commit_ready, o_loaded, o_ckpt_valid, o_err;
  logic [NW-1:0] o_gpr;
  logic [W-1:0]  o_eip, o_eflags;
  logic [15:0]   o_retired;

  logic          s_ready, s_loaded, s_ckpt_valid, s_err;
  logic [NW-1:0] s_gpr;
  logic [W-1:0]  s_eip, s_eflags;
  logic [1:0]    s_retired;

  arch_state_seq u_dut (
    .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .i_gpr(i_gpr), .i_eip(i_eip),
    .i_eflags(i_eflags), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .w_gpr(w_gpr), .gpr_wrmask(gpr_wrmask), .next_eip(next_eip), .next_eflags(next_eflags),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .o_gpr(o_gpr), .o_eip(o_eip),
    .o_eflags(o_eflags), .o_retired(o_retired), .o_loaded(o_loaded),
    .o_ckpt_valid(o_ckpt_valid), .o_err(o_err)
  );

  arch_state_seq #(.CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .i_gpr(i_gpr), .i_eip(i_eip),
    .i_eflags(i_eflags), .commit_valid(commit_valid), .commit_ready(s_ready),
    .w_gpr(w_gpr), .gpr_wrmask(gpr_wrmask), .next_eip(next_eip), .next_eflags(next_eflags),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .o_gpr(s_gpr), .o_eip(s_eip),
    .o_eflags(s_eflags), .o_retired(s_retired), .o_loaded(s_loaded),
    .o_ckpt_valid(s_ckpt_valid), .o_err(s_err)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state as plain arrays and integers.
  logic [W-1:0] m_gpr[N];
  logic [W-1:0] m_eip, m_efl;
  int unsigned  m_ret, m_ret2;
  bit           m_act, m_ckv, m_err;
  logic [W-1:0] sn_gpr[N];
  logic [W-1:0] sn_eip, sn_efl;
  int unsigned  sn_ret, sn_ret2;

  typedef struct {
    logic [NW-1:0] gpr;
    logic [W-1:0]  eip, efl;
    int unsigned   ret, ret2;
    bit            loaded, ckv, err;
  } exp_t;

  exp_t q[$];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_gpr[k]  = '0;
      sn_gpr[k] = '0;
    end
    m_eip = '0; m_efl = 32'h2; sn_eip = '0; sn_efl = 32'h2;
    m_ret = 0; m_ret2 = 0; sn_ret = 0; sn_ret2 = 0;
    m_act = 0; m_ckv = 0; m_err = 0;
  endtask

  task automatic cyc(input bit init, input logic [NW-1:0] igpr, input logic [W-1:0] ieip,
                     input logic [W-1:0] iefl, input bit cv, input logic [N-1:0] mask,
                     input logic [NW-1:0] w, input logic [W-1:0] neip,
                     input logic [W-1:0] nefl, input bit sv, input bit rs);
    bit   rdy, errc;
    exp_t e;
    init_valid = init; i_gpr = igpr; i_eip = ieip; i_eflags = iefl;
    commit_valid = cv; gpr_wrmask = mask; w_gpr = w; next_eip = neip; next_eflags = nefl;
    ckpt_save = sv; ckpt_restore = rs;
    #1;
    rdy = m_act && !init && !rs;
    check("commit_ready", commit_ready, rdy);
    check("small_commit_ready", s_ready, rdy);

    if (init) begin
      for (int k = 0; k < N; k++) m_gpr[k] = igpr[k*W +: W];
      m_eip = ieip; m_efl = iefl; m_ret = 0; m_ret2 = 0;
      m_ckv = 0; m_err = 0; m_act = 1;
    end else begin
      errc = (rs && !m_ckv) || (!m_act && (sv || rs || cv));
      if (m_act && sv && !rs) begin
        for (int k = 0; k < N; k++) sn_gpr[k] = m_gpr[k];
        sn_eip = m_eip; sn_efl = m_efl; sn_ret = m_ret; sn_ret2 = m_ret2;
        m_ckv = 1;
      end else if (m_act && rs && m_ckv) begin
        for (int k = 0; k < N; k++) m_gpr[k] = sn_gpr[k];
        m_eip = sn_eip; m_efl = sn_efl; m_ret = sn_ret; m_ret2 = sn_ret2;
      end
      if (rdy && cv) begin
        for (int k = 0; k < N; k++) if (mask[k]) m_gpr[k] = w[k*W +: W];
        m_eip = neip; m_efl = nefl;
        if (m_ret < 65535) m_ret++;
        if (m_ret2 < 3) m_ret2++;
      end
      if (errc) m_err = 1;
    end

    for (int k = 0; k < N; k++) e.gpr[k*W +: W] = m_gpr[k];
    e.eip = m_eip; e.efl = m_efl; e.ret = m_ret; e.ret2 = m_ret2;
    e.loaded = m_act; e.ckv = m_ckv; e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, '0, '0, '0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic commit(input logic [N-1:0] mask, input logic [NW-1:0] w, input logic [W-1:0] neip);
    cyc(0, '0, '0, '0, 1, mask, w, neip, 32'h46, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gpr"}, o_gpr, '0);
    check({tag, "_eip"}, o_eip, '0);
    check({tag, "_eflags"}, o_eflags, 32'h2);
    check({tag, "_retired"}, o_retired, '0);
    check({tag, "_small_retired"}, s_retired, '0);
    check({tag, "_loaded"}, o_loaded, 1'b0);
    check({tag, "_ckpt_valid"}, o_ckpt_valid, 1'b0);
    check({tag, "_err"}, o_err, 1'b0);
  endtask

  // Monitor: registered outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gpr", o_gpr, e.gpr);
        check("eip", o_eip, e.eip);
        check("eflags", o_eflags, e.efl);
        check("retired", o_retired, e.ret);
        check("small_retired", s_retired, e.ret2);
        check("loaded", o_loaded, e.loaded);
        check("ckpt_valid", o_ckpt_valid, e.ckv);
        check("err", o_err, e.err);
        check("small_gpr", s_gpr, e.gpr);
        check("small_flags", {s_loaded, s_ckpt_valid, s_err, s_eip}, {e.loaded, e.ckv, e.err, e.eip});
        check("small_eflags", s_eflags, e.efl);
      end
    end
  end

  initial begin
    logic [NW-1:0] g, w;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("reset_release");

    // Commit in EMPTY: refused, sets error, state untouched.
    cyc(0, '0, '0, '0, 1, 8'hff, {N{32'hdead_beef}}, 32'h77, 32'h99, 0, 0);
    check("empty_commit_gpr", o_gpr, '0);
    check("empty_commit_err", o_err, 1'b1);
    cyc(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, 1);

    // Init then a single masked commit of EAX.
    for (int k = 0; k < N; k++) g[k*W +: W] = 32'h11 * k;
    g[REG_EAX*W +: W] = 32'd1;
    cyc(1, g, 32'h1000, 32'h2, 0, '0, '0, '0, '0, 0, 0);
    check("init_err_cleared", o_err, 1'b0);
    w = {N{32'hffff_ffff}};
    w[REG_EAX*W +: W] = 32'd5;
    commit(8'h01, w, 32'h1002);
    check("eax_after_commit", o_gpr[REG_EAX*W +: W], 32'd5);
    check("ecx_unchanged", o_gpr[REG_ECX*W +: W], 32'h11);
    check("eip_after_commit", o_eip, 32'h1002);
    check("retired_one", o_retired, 16'd1);

    // Save at retired=3 with EBX=7, overwrite EBX, restore.
    w = '0;
    w[REG_EBX*W +: W] = 32'd7;
    commit(8'h08, w, 32'h1004);
    commit(8'h00, w, 32'h1006);
    cyc(0, '0, '0, '0, 0, '0, '0, '0, '0, 1, 0);
    w[REG_EBX*W +: W] = 32'd9;
    commit(8'h08, w, 32'h1008);
    commit(8'h08, w, 32'h100a);
    cyc(0, '0, '0, '0, 0, '0, '0, '0, '0, 0, 1);
    check("restore_ebx", o_gpr[REG_EBX*W +: W], 32'd7);
    check("restore_retired", o_retired, 16'd3);
    check("restore_ckpt_valid", o_ckpt_valid, 1'b1);

    // Save+commit+restore together: old snapshot wins.
    w[REG_EBX*W +: W] = 32'h55;
    commit(8'h08, w, 32'h2000);
    cyc(0, '0, '0, '0, 1, 8'hff, {N{32'h1234_5678}}, 32'h3000, 32'h3, 1, 1);
    check("triple_ebx", o_gpr[REG_EBX*W +: W], 32'd7);
    check("triple_retired", o_retired, 16'd3);

    // Back-to-back commits, then async reset between edges.
    for (int i = 0; i < 3; i++) commit(8'hff, {N{$urandom()}}, $urandom());
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_midstream");
    model_reset();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    commit_valid = 1'b0;
    idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        g[k*W +: W] = $urandom();
        w[k*W +: W] = $urandom();
      end
      cyc(($urandom_range(0, 49) == 0) || (i == 0), g, $urandom(), $urandom(),
          $urandom_range(0, 9) < 7, N'($urandom()), w, $urandom(), $urandom(),
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    idle();

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
